// File: rtl/io_bus_fabric.sv
// io_bus_fabric: IO-page interconnect between maxicore32 and word-wide peripherals.
// Decodes the IO page into one-hot chip selects, inserts per-channel wait states,
// emits single-cycle read/write pulses, registers read data and reports errors.
// The address port carries CPU byte-address bits [31:2], so byte-address bit k
// sits at address[k-2]. Supports up to 64 channels.

module io_bus_fabric #(
    parameter int                        NUM_CHANNELS   = 16,
    parameter logic [7:0]                IO_PAGE        = 8'h0f,
    parameter logic [4*NUM_CHANNELS-1:0] WAIT_STATES    = '0,
    parameter int                        TIMEOUT_CYCLES = 255
) (
    input  logic                        clock,
    input  logic                        n_reset,
    input  logic [29:0]                 address,
    input  logic [3:0]                  data_strobes,
    input  logic                        read,
    input  logic                        write,
    output logic [NUM_CHANNELS-1:0]     cs,
    output logic                        chan_read,
    output logic                        chan_write,
    input  logic [32*NUM_CHANNELS-1:0]  chan_data_in,
    input  logic [NUM_CHANNELS-1:0]     chan_data_valid,
    output logic [31:0]                 data_out,
    output logic                        ready,
    output logic                        bus_error,
    output logic [7:0]                  error_count
);

    localparam int         IDX_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [6:0] CHAN_LIMIT    = 7'(NUM_CHANNELS);
    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK,
        ST_ERROR,
        ST_HOLD
    } state_t;

    state_t state;
    state_t next_state;

    logic [7:0]       addr_page;
    logic [5:0]       addr_idx;
    logic [IDX_W-1:0] addr_chan;
    logic             unused_addr_bits;
    logic             hit;
    logic             req_bad;

    logic [IDX_W-1:0] sel_idx;
    logic             sel_write;
    logic [3:0]       wc;
    logic [7:0]       to_cnt;

    logic             req_load;
    logic             wc_dec;
    logic             to_inc;
    logic             data_load;
    logic             err_load;
    logic             err_read;

    logic [31:0]      chan_word [NUM_CHANNELS];
    logic [3:0]       chan_ws   [NUM_CHANNELS];

    // Split the packed peripheral data and wait-state parameter into per-channel words
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
        assign chan_word[g] = chan_data_in[32*g +: 32];
        assign chan_ws[g]   = WAIT_STATES[4*g +: 4];
    end

    // Only the page byte and the word index take part in decoding; the rest alias
    assign addr_page        = address[29:22];
    assign addr_idx         = address[5:0];
    assign addr_chan        = addr_idx[IDX_W-1:0];
    assign unused_addr_bits = ^address[21:6];

    assign hit     = (addr_page == IO_PAGE) && (read || write);
    assign req_bad = (read && write)
                   || ({1'b0, addr_idx} >= CHAN_LIMIT)
                   || (write && (data_strobes != 4'b1111));

    // State register; reset drops straight back to idle from anywhere
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the combinational strobes and datapath controls
    always_comb begin
        next_state = state;
        cs         = '0;
        chan_read  = 1'b0;
        chan_write = 1'b0;
        ready      = 1'b0;
        bus_error  = 1'b0;
        req_load   = 1'b0;
        wc_dec     = 1'b0;
        to_inc     = 1'b0;
        data_load  = 1'b0;
        err_load   = 1'b0;
        err_read   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (hit) begin
                    if (req_bad) begin
                        next_state = ST_ERROR;
                        err_load   = 1'b1;
                        err_read   = read;
                    end else begin
                        next_state = ST_WAIT;
                        req_load   = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cs[sel_idx] = 1'b1;
                if (!read && !write) begin
                    next_state = ST_IDLE;
                end else if (wc != 4'd0) begin
                    wc_dec = 1'b1;
                end else if (sel_write) begin
                    chan_write = 1'b1;
                    next_state = ST_ACK;
                end else if (chan_data_valid[sel_idx]) begin
                    chan_read  = 1'b1;
                    data_load  = 1'b1;
                    next_state = ST_ACK;
                end else if (to_cnt == TIMEOUT_LIMIT) begin
                    err_load   = 1'b1;
                    err_read   = 1'b1;
                    next_state = ST_ERROR;
                end else begin
                    to_inc = 1'b1;
                end
            end
            ST_ACK: begin
                ready      = 1'b1;
                next_state = ST_HOLD;
            end
            ST_ERROR: begin
                ready      = 1'b1;
                bus_error  = 1'b1;
                next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (!read && !write) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Latch the accepted request and run the wait-state and timeout counters
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            sel_idx   <= '0;
            sel_write <= 1'b0;
            wc        <= 4'd0;
            to_cnt    <= 8'd0;
        end else if (req_load) begin
            sel_idx   <= addr_chan;
            sel_write <= write;
            wc        <= chan_ws[addr_chan];
            to_cnt    <= 8'd0;
        end else begin
            if (wc_dec) begin
                wc <= wc - 4'd1;
            end
            if (to_inc) begin
                to_cnt <= to_cnt + 8'd1;
            end
        end
    end

    // Read data is captured with the read pulse and zeroed on entry to a read error,
    // so it is already valid in the cycle ready is raised
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            data_out <= 32'h0;
        end else if (data_load) begin
            data_out <= chan_word[sel_idx];
        end else if (err_load && err_read) begin
            data_out <= 32'h0;
        end
    end

    // Saturating error counter, bumped on entry to the error state so it lines up with bus_error
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            error_count <= 8'h00;
        end else if (err_load && (error_count != 8'hff)) begin
            error_count <= error_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_io_bus_fabric.sv
// tb_io_bus_fabric: scoreboard bench for io_bus_fabric with directed accesses.
// Stimulus pushes expected ready responses and channel pulses into queues;
// a monitor on the falling edge pops and compares whenever the DUT presents one.

module tb_io_bus_fabric;

    localparam int NCH = 16;

    typedef struct {
        int          cyc;
        logic        err;
        logic        chk_data;
        logic [31:0] data;
        logic [7:0]  cnt;
    } resp_t;

    typedef struct {
        int          cyc;
        logic        rd;
        logic [15:0] cs;
    } pulse_t;

    logic                 clock;
    logic                 n_reset;
    logic [29:0]          address;
    logic [3:0]           data_strobes;
    logic                 read;
    logic                 write;
    logic [NCH-1:0]       cs;
    logic                 chan_read;
    logic                 chan_write;
    logic [32*NCH-1:0]    chan_data_in;
    logic [NCH-1:0]       chan_data_valid;
    logic [31:0]          data_out;
    logic                 ready;
    logic                 bus_error;
    logic [7:0]           error_count;

    int     total;
    int     bad;
    int     cyc;
    int     cs_cycles;
    logic [7:0] exp_cnt;
    resp_t  resp_q[$];
    pulse_t pulse_q[$];
    resp_t  mon_r;
    pulse_t mon_p;

    io_bus_fabric #(
        .NUM_CHANNELS   (NCH),
        .IO_PAGE        (8'h0f),
        .WAIT_STATES    (64'h0000_0000_0030_8000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock           (clock),
        .n_reset         (n_reset),
        .address         (address),
        .data_strobes    (data_strobes),
        .read            (read),
        .write           (write),
        .cs              (cs),
        .chan_read       (chan_read),
        .chan_write      (chan_write),
        .chan_data_in    (chan_data_in),
        .chan_data_valid (chan_data_valid),
        .data_out        (data_out),
        .ready           (ready),
        .bus_error       (bus_error),
        .error_count     (error_count)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used to time-stamp hits and responses
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Count cycles in which any chip select is asserted
    initial cs_cycles = 0;
    always @(negedge clock) if (cs != '0) cs_cycles <= cs_cycles + 1;

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] byte_addr, input logic rd, input logic wr,
                                 input logic [3:0] strb);
        @(posedge clock);
        #1;
        address      = byte_addr[31:2];
        read         = rd;
        write        = wr;
        data_strobes = strb;
    endtask

    task automatic releaseBus();
        @(posedge clock);
        #1;
        address      = '0;
        read         = 1'b0;
        write        = 1'b0;
        data_strobes = 4'h0;
    endtask

    task automatic waitReady(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!ready && n < budget);
        if (!ready) begin
            total++;
            bad++;
            $display("[TB] FAIL ready timeout: got 0 expected 1 within %0d cycles", budget);
        end
    endtask

    // Issue one access, queue its expected pulse and response, wait for completion
    task automatic runAccess(input logic [31:0] a, input logic rd, input logic wr, input logic [3:0] strb,
                             input int lat, input logic err, input int pulse_lat,
                             input logic chk_data, input logic [31:0] data);
        int          t;
        logic [15:0] one_hot;
        applyStimulus(a, rd, wr, strb);
        t = cyc;
        if (err && exp_cnt != 8'hff) exp_cnt = exp_cnt + 8'd1;
        resp_q.push_back('{t + lat, err, chk_data, data, exp_cnt});
        if (pulse_lat >= 0) begin
            one_hot = 16'h0001 << a[5:2];
            pulse_q.push_back('{t + pulse_lat, rd, one_hot});
        end
        waitReady(lat + 5);
        releaseBus();
    endtask

    // Monitor: compare every ready strobe and every channel pulse against the queues
    always @(negedge clock) begin
        if (ready) begin
            if (resp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected ready: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                mon_r = resp_q.pop_front();
                checkOutput("ready cycle", 64'(cyc), 64'(mon_r.cyc));
                checkOutput("bus_error", 64'(bus_error), 64'(mon_r.err));
                if (mon_r.chk_data) checkOutput("data_out", 64'(data_out), 64'(mon_r.data));
                checkOutput("error_count", 64'(error_count), 64'(mon_r.cnt));
            end
        end
        if (chan_read || chan_write) begin
            if (pulse_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected pulse: got rd=%0b wr=%0b expected none", chan_read, chan_write);
            end else begin
                mon_p = pulse_q.pop_front();
                checkOutput("pulse cycle", 64'(cyc), 64'(mon_p.cyc));
                checkOutput("chan_read", 64'(chan_read), 64'(mon_p.rd));
                checkOutput("chan_write", 64'(chan_write), 64'(!mon_p.rd));
                checkOutput("pulse cs", 64'(cs), 64'(mon_p.cs));
            end
        end
        if (bus_error && !ready) begin
            total++;
            bad++;
            $display("[TB] FAIL bus_error without ready: got ready 0 expected 1");
        end
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int csc0;
        int t;
        total           = 0;
        bad             = 0;
        exp_cnt         = 8'h00;
        n_reset         = 1'b0;
        address         = '0;
        data_strobes    = 4'h0;
        read            = 1'b0;
        write           = 1'b0;
        chan_data_in    = '0;
        chan_data_valid = '0;
        chan_data_in[32*5 +: 32] = 32'hdeadbeef;
        chan_data_in[32*2 +: 32] = 32'h12345678;
        chan_data_in[32*3 +: 32] = 32'hcafef00d;
        chan_data_valid[5] = 1'b1;
        chan_data_valid[2] = 1'b1;

        // Reset state
        @(negedge clock);
        checkOutput("reset cs", 64'(cs), 64'h0);
        checkOutput("reset ready", 64'(ready), 64'h0);
        checkOutput("reset bus_error", 64'(bus_error), 64'h0);
        checkOutput("reset data_out", 64'(data_out), 64'h0);
        checkOutput("reset error_count", 64'(error_count), 64'h0);
        checkOutput("reset pulses", 64'({chan_read, chan_write}), 64'h0);
        repeat (2) @(posedge clock);
        #1 n_reset = 1'b1;
        repeat (2) @(posedge clock);

        $display("[TB] write ch2, no wait states");
        runAccess(32'h0f000008, 1'b0, 1'b1, 4'hf, 2, 1'b0, 1, 1'b0, 32'h0);

        $display("[TB] read ch5, three wait states");
        csc0 = cs_cycles;
        runAccess(32'h0f000014, 1'b1, 1'b0, 4'hf, 5, 1'b0, 4, 1'b1, 32'hdeadbeef);
        checkOutput("ch5 cs cycles", 64'(cs_cycles - csc0), 64'd4);

        $display("[TB] read ch1 timeout");
        runAccess(32'h0f000004, 1'b1, 1'b0, 4'hf, 6, 1'b1, -1, 1'b1, 32'h0);

        $display("[TB] request errors");
        runAccess(32'h0f000008, 1'b1, 1'b0, 4'hf, 2, 1'b0, 1, 1'b1, 32'h12345678);
        runAccess(32'h0f000008, 1'b0, 1'b1, 4'h3, 1, 1'b1, -1, 1'b1, 32'h12345678);
        runAccess(32'h0f000050, 1'b1, 1'b0, 4'hf, 1, 1'b1, -1, 1'b1, 32'h0);
        runAccess(32'h0f000008, 1'b1, 1'b1, 4'hf, 1, 1'b1, -1, 1'b0, 32'h0);
        for (int i = 0; i < 260; i++) begin
            runAccess(32'h0f000000, 1'b0, 1'b1, 4'h0, 1, 1'b1, -1, 1'b0, 32'h0);
        end
        @(negedge clock);
        checkOutput("error_count saturated", 64'(error_count), 64'hff);

        $display("[TB] abort during wait states");
        runAccess(32'h0f000008, 1'b1, 1'b0, 4'hf, 2, 1'b0, 1, 1'b1, 32'h12345678);
        applyStimulus(32'h0f00000c, 1'b1, 1'b0, 4'hf);
        t = cyc;
        repeat (3) @(posedge clock);
        #1;
        read = 1'b0;
        @(negedge clock);
        checkOutput("abort cs before drop", 64'(cs), 64'h0008);
        checkOutput("abort cycle", 64'(cyc), 64'(t + 3));
        @(negedge clock);
        checkOutput("abort cs cleared", 64'(cs), 64'h0);
        checkOutput("abort no ready", 64'(ready), 64'h0);
        checkOutput("abort data_out kept", 64'(data_out), 64'h12345678);
        releaseBus();

        $display("[TB] reset during wait states");
        applyStimulus(32'h0f00000c, 1'b0, 1'b1, 4'hf);
        repeat (2) @(posedge clock);
        #1 n_reset = 1'b0;
        #1;
        checkOutput("mid reset cs", 64'(cs), 64'h0);
        checkOutput("mid reset pulses", 64'({chan_read, chan_write}), 64'h0);
        checkOutput("mid reset ready", 64'({ready, bus_error}), 64'h0);
        checkOutput("mid reset data_out", 64'(data_out), 64'h0);
        checkOutput("mid reset error_count", 64'(error_count), 64'h0);
        exp_cnt = 8'h00;
        address = '0;
        write   = 1'b0;
        data_strobes = 4'h0;
        @(posedge clock);
        #1 n_reset = 1'b1;
        @(posedge clock);

        $display("[TB] off-page access and held read");
        csc0 = cs_cycles;
        applyStimulus(32'h00000010, 1'b1, 1'b0, 4'hf);
        repeat (4) @(posedge clock);
        @(negedge clock);
        checkOutput("off-page cs cycles", 64'(cs_cycles - csc0), 64'd0);
        releaseBus();
        csc0 = cs_cycles;
        applyStimulus(32'h0f000008, 1'b1, 1'b0, 4'hf);
        t = cyc;
        resp_q.push_back('{t + 2, 1'b0, 1'b1, 32'h12345678, exp_cnt});
        pulse_q.push_back('{t + 1, 1'b1, 16'h0004});
        waitReady(8);
        repeat (5) @(posedge clock);
        @(negedge clock);
        checkOutput("held read cs", 64'(cs), 64'h0);
        releaseBus();
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("held read cs cycles", 64'(cs_cycles - csc0), 64'd1);
        checkOutput("responses drained", 64'(resp_q.size()), 64'd0);
        checkOutput("pulses drained", 64'(pulse_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
